// File: rtl/demux_pkg.sv
// ============================================================================
// demux_pkg
// Shared lane count, select width and collector state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package demux_pkg;
    localparam int LANES = 4;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;
endpackage

`default_nettype wire

// File: rtl/demux1t4_lane_dec.sv
// ============================================================================
// demux1t4_lane_dec
// Turns a lane index plus enable into a one-hot lane write enable.
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux1t4_lane_dec
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0] lane,
    input  logic             en,
    output logic [LANES-1:0] we
);

    always_comb begin
        we = '0;
        if (en) begin
            we[lane] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/demux1t4_collector.sv
// ============================================================================
// demux1t4_collector
// Steers serial words into 4 lane slots and drains assembled frames on a
// valid/ready port; the assembly bank and output bank form a double buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux1t4_collector
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   sel_mode,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_mask
);

    state_t                 state;
    state_t                 next_state;
    logic [SEL_W-1:0]       slot;
    logic [SEL_W-1:0]       cnt;
    logic [SEL_W-1:0]       lane;
    logic [LANES*WIDTH-1:0] asm_data;
    logic [LANES*WIDTH-1:0] merged_data;
    logic [LANES-1:0]       asm_mask;
    logic [LANES-1:0]       merged_mask;
    logic [LANES-1:0]       we;
    logic                   acc;
    logic                   xfer;
    logic                   close;
    logic                   load_out;

    assign in_ready = (state == COLLECT);
    assign acc      = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;
    assign lane     = sel_mode ? in_sel : slot;

    demux1t4_lane_dec u_lane_dec (
        .lane (lane),
        .en   (acc),
        .we   (we)
    );

    // Assembly bank with the current word folded in; in HOLD we is zero so
    // this is just the parked frame.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign merged_data[i*WIDTH +: WIDTH] = we[i] ? in_data : asm_data[i*WIDTH +: WIDTH];
    end
    assign merged_mask = asm_mask | we;

    assign close    = acc & ((cnt == SEL_W'(LANES - 1)) | in_last);
    assign load_out = (close & (~out_valid | out_ready)) | ((state == HOLD) & xfer);

    always_comb begin
        next_state = state;
        case (state)
            COLLECT: if (close && !load_out) next_state = HOLD;
            HOLD:    if (xfer)               next_state = COLLECT;
            default:                         next_state = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mask  <= '0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            out_data  <= merged_data;
            out_mask  <= merged_mask;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_data <= '0;
            asm_mask <= '0;
            cnt      <= '0;
            slot     <= '0;
        end else if (load_out) begin
            asm_data <= '0;
            asm_mask <= '0;
            cnt      <= '0;
            slot     <= '0;
        end else if (close) begin
            // Output busy: park the completed frame until the drain frees it.
            asm_data <= merged_data;
            asm_mask <= merged_mask;
            cnt      <= '0;
            slot     <= '0;
        end else if (acc) begin
            asm_data <= merged_data;
            asm_mask <= merged_mask;
            cnt      <= cnt + 1'b1;
            slot     <= slot + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_demux1t4_collector.sv
// ============================================================================
// tb_demux1t4_collector
// Scoreboard bench: frame model pushes expected frames, monitor pops on drain.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_demux1t4_collector;

    localparam int W = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic         sel_mode;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [4*W-1:0] out_data;
    logic [3:0]   out_mask;

    int vectors     = 0;
    int miscompares = 0;
    int ready_mode  = 0;   // 0: always ready, 1: never ready, 2: random

    logic [7:0] exp_q[$];  // {mask, data} of each closed frame, oldest first
    logic [3:0] m_data;
    logic [3:0] m_mask;
    int         m_n;

    always #5 clk = ~clk;

    demux1t4_collector #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .sel_mode  (sel_mode),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a set of lanes filled word by word; it
    // closes after 4 words or on in_last and joins the outstanding list.
    always @(posedge clk) begin
        int lane;
        if (rst) begin
            exp_q.delete();
            m_data = '0;
            m_mask = '0;
            m_n    = 0;
        end else if (in_valid && in_ready) begin
            lane = sel_mode ? int'(in_sel) : m_n;
            m_data[lane] = in_data[0];
            m_mask[lane] = 1'b1;
            m_n++;
            if (m_n == 4 || in_last) begin
                exp_q.push_back({m_mask, m_data});
                m_data = '0;
                m_mask = '0;
                m_n    = 0;
            end
        end
    end

    // Monitor: at most two frames can be outstanding; the oldest is on the port.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            if (out_valid && exp_q.size() > 0) begin
                check("out_frame", 32'({out_mask, out_data}), 32'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    task automatic send_word(input logic d, input logic [1:0] s, input logic m, input logic l);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        sel_mode = m;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready=0 after 100 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_sel = '0; sel_mode = 1'b0; in_last = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_mask", 32'(out_mask), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 1);

        // Auto mode, back-to-back frames
        send_word(1, 0, 0, 0); send_word(0, 0, 0, 0);
        send_word(1, 0, 0, 0); send_word(1, 0, 0, 0);
        check("auto_valid", 32'(out_valid), 1);
        check("auto_data", 32'(out_data), 32'h0000000D);
        check("auto_mask", 32'(out_mask), 32'h0000000F);
        send_word(0, 0, 0, 0); send_word(1, 0, 0, 0);
        send_word(1, 0, 0, 0); send_word(0, 0, 0, 0);
        check("auto2_data", 32'(out_data), 32'h00000006);

        // Early close, then slot restarts at lane 0
        send_word(1, 0, 0, 0); send_word(1, 0, 0, 1);
        check("last_data", 32'(out_data), 32'h00000003);
        check("last_mask", 32'(out_mask), 32'h00000003);
        send_word(0, 0, 0, 0); send_word(1, 0, 0, 1);
        check("restart_data", 32'(out_data), 32'h00000002);
        check("restart_mask", 32'(out_mask), 32'h00000003);

        // Manual mode with a lane overwrite
        send_word(1, 3, 1, 0); send_word(0, 3, 1, 0);
        send_word(1, 0, 1, 0); send_word(1, 2, 1, 0);
        check("manual_data", 32'(out_data), 32'h00000005);
        check("manual_mask", 32'(out_mask), 32'h0000000D);

        // Backpressure: two frames stall, second parks in HOLD
        @(negedge clk); ready_mode = 1;
        @(posedge clk); #2;
        send_word(1, 0, 0, 0); send_word(0, 0, 0, 0);
        send_word(0, 0, 0, 0); send_word(0, 0, 0, 0);
        send_word(0, 0, 0, 0); send_word(1, 0, 0, 0);
        send_word(1, 0, 0, 0); send_word(0, 0, 0, 0);
        idle(2);
        check("hold_in_ready", 32'(in_ready), 0);
        check("hold_data", 32'(out_data), 32'h00000001);
        @(negedge clk); ready_mode = 0;
        @(posedge clk); #2;
        check("hold_still_blocked", 32'(in_ready), 0);
        @(posedge clk); #1;
        check("release_valid", 32'(out_valid), 1);
        check("release_in_ready", 32'(in_ready), 1);
        check("release_data", 32'(out_data), 32'h00000006);

        // Close and drain on the same edge
        @(negedge clk); ready_mode = 1;
        @(posedge clk); #2;
        send_word(1, 0, 0, 0); send_word(1, 0, 0, 0);
        send_word(1, 0, 0, 0); send_word(1, 0, 0, 0);
        send_word(0, 0, 0, 0); send_word(1, 0, 0, 0); send_word(0, 0, 0, 0);
        @(negedge clk); ready_mode = 0;
        @(posedge clk); #2;
        send_word(1, 0, 0, 0);
        check("swap_valid", 32'(out_valid), 1);
        check("swap_data", 32'(out_data), 32'h0000000A);

        // Asynchronous reset mid-frame with a pending output
        @(negedge clk); ready_mode = 1;
        @(posedge clk); #2;
        send_word(1, 0, 0, 0); send_word(1, 0, 0, 0);
        send_word(0, 0, 0, 0); send_word(1, 0, 0, 0);
        send_word(1, 0, 0, 0); send_word(1, 0, 0, 0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_data", 32'(out_data), 0);
        check("arst_mask", 32'(out_mask), 0);
        ready_mode = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_word(0, 0, 0, 0); send_word(1, 0, 0, 0);
        send_word(1, 0, 0, 0); send_word(0, 0, 0, 0);
        check("post_rst_data", 32'(out_data), 32'h00000006);
        check("post_rst_mask", 32'(out_mask), 32'h0000000F);

        // Randomized traffic under random backpressure
        @(negedge clk); ready_mode = 2;
        @(posedge clk); #2;
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_word(1'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
        end
        send_word(1, 0, 0, 1);

        @(negedge clk); ready_mode = 0;
        begin
            int budget = 0;
            while (exp_q.size() != 0 && budget < 50) begin
                budget++;
                @(posedge clk);
            end
        end
        @(negedge clk); #1;
        check("drain_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
